// File: rtl/hssi_prmgmt_responder.sv
// AFU-side HSSI PR-management endpoint: edge-triggered register access over cmd/addr/din,
// 2-stage read pipe on dout, and the a2f_init_start / f2a_init_done handshake sequencer.
module hssi_prmgmt_responder #(
  parameter int NUM_REGS     = 8,
  parameter int INIT_DLY     = 16,
  parameter int INIT_TIMEOUT = 4096
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [15:0]              prmgmt_cmd,
  input  logic [15:0]              prmgmt_addr,
  input  logic [31:0]              prmgmt_din,
  input  logic                     prmgmt_freeze,
  input  logic                     prmgmt_ram_ena,
  output logic [31:0]              prmgmt_dout,
  output logic                     prmgmt_fatal_err,
  output logic                     init_start,
  input  logic                     init_done,
  output logic [NUM_REGS*32-1:0]   cfg_q
);

  localparam int AW      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int CNT_MAX = (INIT_TIMEOUT > INIT_DLY) ? INIT_TIMEOUT : INIT_DLY;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START_DLY = 3'd1;
  localparam logic [2:0] S_WAIT_DONE = 3'd2;
  localparam logic [2:0] S_RUN       = 3'd3;
  localparam logic [2:0] S_ERR       = 3'd4;

  logic [1:0]    cmd_hist_q;
  logic [31:0]   regs_q [NUM_REGS];
  logic          rd_vld_q;
  logic [31:0]   rd_data_q;
  logic [31:0]   dout_q;
  logic          fatal_q, fatal_d;
  logic [7:0]    err_cnt_q, err_cnt_d;
  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          fsm_fatal;

  logic          accept, wr_edge, rd_edge;
  logic          wr_go, rd_go, conflict, bad_access;
  logic          addr_ok, addr_zero;
  logic [AW-1:0] addr_idx;
  logic [31:0]   status, rd_mux;
  logic          unused_cmd;

  // Only bits [1:0] carry meaning; the rest of the command word is reserved.
  assign unused_cmd = ^prmgmt_cmd[15:2];

  assign accept     = ~prmgmt_freeze & prmgmt_ram_ena;
  assign wr_edge    = prmgmt_cmd[0] & ~cmd_hist_q[0];
  assign rd_edge    = prmgmt_cmd[1] & ~cmd_hist_q[1];
  assign wr_go      = accept & wr_edge & ~rd_edge;
  assign rd_go      = accept & rd_edge & ~wr_edge;
  assign conflict   = accept & wr_edge & rd_edge;
  assign addr_ok    = prmgmt_addr < 16'(NUM_REGS);
  assign addr_zero  = prmgmt_addr == 16'd0;
  assign addr_idx   = prmgmt_addr[AW-1:0];
  assign bad_access = (wr_go | rd_go) & ~addr_ok;

  assign status = {16'h0000, err_cnt_q, 3'b000, fatal_q, init_done, state_q};

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    rd_mux = 32'h0;
    if (addr_zero)    rd_mux = status;
    else if (addr_ok) rd_mux = regs_q[addr_idx];
  end

  always_comb begin
    err_cnt_d = err_cnt_q;
    if ((conflict | bad_access) && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    fsm_fatal = 1'b0;
    if (prmgmt_freeze) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_START_DLY;
          cnt_d   = '0;
        end
        S_START_DLY: begin
          if (cnt_q == CW'(INIT_DLY - 1)) begin
            state_d = S_WAIT_DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_WAIT_DONE: begin
          if (init_done) begin
            state_d = S_RUN;
            cnt_d   = '0;
          end else if (cnt_q == CW'(INIT_TIMEOUT - 1)) begin
            state_d   = S_ERR;
            cnt_d     = '0;
            fsm_fatal = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        // Entering RUN needs init_done high, so a low level here is always a fall.
        S_RUN: begin
          if (!init_done) begin
            state_d   = S_ERR;
            fsm_fatal = 1'b1;
          end
        end
        S_ERR:   state_d = S_ERR;
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign fatal_d = fatal_q | conflict | fsm_fatal;

  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_hist_q <= 2'b00;
      rd_vld_q   <= 1'b0;
      rd_data_q  <= 32'h0;
      dout_q     <= 32'h0;
      fatal_q    <= 1'b0;
      err_cnt_q  <= 8'h00;
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      // NOTE: the register file is visible on cfg_q, so it must come out of reset as zeros.
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= 32'h0;
    end else begin
      cmd_hist_q <= prmgmt_cmd[1:0];
      rd_vld_q   <= rd_go;
      if (rd_go)    rd_data_q <= rd_mux;
      if (rd_vld_q) dout_q    <= rd_data_q;
      fatal_q    <= fatal_d;
      err_cnt_q  <= err_cnt_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      // Address 0 is the read-only status word; writes to it are silently dropped.
      if (wr_go && addr_ok && !addr_zero) regs_q[addr_idx] <= prmgmt_din;
    end
  end

  always_comb begin
    cfg_q = '0;
    for (int i = 0; i < NUM_REGS; i++) cfg_q[32*i +: 32] = regs_q[i];
  end

  assign prmgmt_dout      = dout_q;
  assign prmgmt_fatal_err = fatal_q;
  assign init_start       = (state_q == S_WAIT_DONE) | (state_q == S_RUN);

endmodule
